// File: rtl/instr_encoder_if.sv
// Field-tuple input stream and instruction-memory write bus of instr_encoder.
// master: the environment (producer plus memory); slave: the encoder itself.
interface instr_encoder_if;
   // Field tuple handshake
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  fmt;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic [25:0] addr;

   // Instruction memory write port
   logic        iwen;
   logic [31:0] iaddr;
   logic [31:0] istore;
   logic        iwait;

   modport master (
      output in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm, addr, iwait,
      input  in_ready, iwen, iaddr, istore
   );

   modport slave (
      input  in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm, addr, iwait,
      output in_ready, iwen, iaddr, istore
   );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs MIPS R/I/J field tuples into 32-bit words, queues them
// in a small FIFO and writes them to instruction memory at consecutive word
// addresses starting from BASE_ADDR.
// Optional build macro INSTR_ENCODER_CKSUM_EN adds a running XOR checksum
// output (cksum) over every completed memory write.
module instr_encoder #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic           CLK,
   input  logic           RST,
   instr_encoder_if.slave bus,
   input  logic           restart,
   output logic           err,
   output logic           busy
`ifdef INSTR_ENCODER_CKSUM_EN
   ,
   output logic [31:0]    cksum
`endif
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_WRITE = 1'b1
   } state_t;

   state_t      state_q;
   state_t      state_d;

   // FIFO storage holds only the encoded word; pointers carry one extra wrap bit
   logic [31:0] fifo_mem [DEPTH];
   logic [AW:0] wr_ptr_q;
   logic [AW:0] rd_ptr_q;
   logic [AW:0] rd_ptr_inc;
   logic [AW:0] count;
   logic        full;
   logic        empty;

   logic        restart_pend_q;
   logic        in_ready_w;
   logic        accept;
   logic        push;
   logic [31:0] enc_word;

   logic [31:0] iaddr_q;
   logic [31:0] istore_q;
   logic        err_p1;

   // Write-FSM strobes
   logic        iwen_w;
   logic        done;
   logic        pop;
   logic        flush;
   logic        load_head;
   logic [31:0] head_word;

   function automatic logic [31:0] encode_word(
      input logic [1:0]  f,
      input logic [5:0]  op,
      input logic [4:0]  f_rs,
      input logic [4:0]  f_rt,
      input logic [4:0]  f_rd,
      input logic [4:0]  f_shamt,
      input logic [5:0]  f_funct,
      input logic [15:0] f_imm,
      input logic [25:0] f_addr
   );
      logic [31:0] w;
      case (f)
         2'd0:    w = {op, f_rs, f_rt, f_rd, f_shamt, f_funct};
         2'd1:    w = {op, f_rs, f_rt, f_imm};
         2'd2:    w = {op, f_addr};
         default: w = 32'd0;
      endcase
      return w;
   endfunction

   assign count      = wr_ptr_q - rd_ptr_q;
   assign rd_ptr_inc = rd_ptr_q + ONE_CNT;
   assign full       = (count == FULL_CNT);
   assign empty      = (count == '0);

   // A pending restart also blocks input so nothing lands behind the flush
   assign in_ready_w = !full && !restart && !restart_pend_q;
   assign accept     = bus.in_valid && in_ready_w;
   assign push       = accept && (bus.fmt != 2'd3);

   // Encode the incoming tuple; only the packed word is ever stored
   always_comb begin
      enc_word = encode_word(bus.fmt, bus.opcode, bus.rs, bus.rt, bus.rd,
                             bus.shamt, bus.funct, bus.imm, bus.addr);
   end

   // Write FSM: state register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Write FSM: next state; stay in WRITE while another word is ready so writes run back-to-back
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (!restart && (!empty || push)) begin
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (!bus.iwait &&
                (restart || restart_pend_q || ((count <= ONE_CNT) && !push))) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Write FSM: outputs and strobes; an empty FIFO bypasses the incoming word straight to the bus
   always_comb begin
      iwen_w    = 1'b0;
      done      = 1'b0;
      pop       = 1'b0;
      flush     = 1'b0;
      load_head = 1'b0;
      head_word = enc_word;
      case (state_q)
         S_IDLE: begin
            if (restart) begin
               flush = 1'b1;
            end else if (!empty) begin
               load_head = 1'b1;
               head_word = fifo_mem[rd_ptr_q[AW-1:0]];
            end else if (push) begin
               load_head = 1'b1;
               head_word = enc_word;
            end
         end
         S_WRITE: begin
            iwen_w = 1'b1;
            if (!bus.iwait) begin
               done = 1'b1;
               pop  = 1'b1;
               if (restart || restart_pend_q) begin
                  flush = 1'b1;
               end else if (count > ONE_CNT) begin
                  load_head = 1'b1;
                  head_word = fifo_mem[rd_ptr_inc[AW-1:0]];
               end else if (push) begin
                  load_head = 1'b1;
                  head_word = enc_word;
               end
            end
         end
         default: begin
            iwen_w = 1'b0;
         end
      endcase
   end

   // FIFO storage write; contents are don't-care until a pointer covers them
   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_mem[wr_ptr_q[AW-1:0]] <= enc_word;
      end
   end

   // FIFO pointers, restart tracking, address counter, write data and error pulse
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         restart_pend_q <= 1'b0;
         iaddr_q        <= BASE_ADDR;
         istore_q       <= 32'd0;
         err_p1         <= 1'b0;
      end else begin
         err_p1 <= accept && (bus.fmt == 2'd3);

         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) begin
               wr_ptr_q <= wr_ptr_q + ONE_CNT;
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_inc;
            end
         end

         // A restart seen mid-write waits for the head write to finish
         if (flush) begin
            restart_pend_q <= 1'b0;
         end else if (restart && (state_q == S_WRITE)) begin
            restart_pend_q <= 1'b1;
         end

         if (flush) begin
            iaddr_q <= BASE_ADDR;
         end else if (done) begin
            iaddr_q <= iaddr_q + 32'd4;
         end

         if (load_head) begin
            istore_q <= head_word;
         end
      end
   end

`ifdef INSTR_ENCODER_CKSUM_EN
   logic [31:0] cksum_q;

   // Running XOR of every completed write; a flush starts a fresh program image
   always_ff @(posedge CLK) begin
      if (RST) begin
         cksum_q <= 32'd0;
      end else if (flush) begin
         cksum_q <= 32'd0;
      end else if (done) begin
         cksum_q <= cksum_q ^ istore_q;
      end
   end

   assign cksum = cksum_q;
`endif

   assign bus.in_ready = in_ready_w;
   assign bus.iwen     = iwen_w;
   assign bus.iaddr    = iaddr_q;
   assign bus.istore   = istore_q;
   assign err          = err_p1;
   assign busy         = !empty || iwen_w;

endmodule
